sga_step_scheduler: RTL and testbench

- Movement sequencer for the Snake Game Arcade datapath; produces the is_at_apple, is_at_border, is_at_body and end_play_time status inputs of the game control unit.
- On every game tick it does the following:
  - computes the next head position from the latched direction;
  - checks the border;
  - walks the body memory, shifting every segment one slot toward the tail and comparing each with the new head;
  - writes the new head and reports the result as a one-cycle pulse.
- Sits between the buttons, the control unit and the body-position RAM in the datapath.

---
 rtl/sga_pkg.sv | 50 +++++
 rtl/sga_tick_timer.sv | 31 +++
 rtl/sga_step_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_sga_step_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sga_pkg.sv
// Shared types for the Snake Game Arcade step scheduler:
// direction codes, FSM states and {x, y} position packing.
package sga_pkg;

  localparam int POS_W = 6;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT,
    S_CALC,
    S_RD,
    S_SHIFT,
    S_WHEAD,
    S_REPORT
  } state_t;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } pos_t;

  // Opposite pairs differ only in the low bit.
  function automatic dir_t dir_opposite(input dir_t d);
    return d ^ 2'b01;
  endfunction

  function automatic pos_t pos_pack(
    input logic [2:0] x,
    input logic [2:0] y
  );
    pos_t p;
    p.x = x;
    p.y = y;
    return p;
  endfunction

  function automatic pos_t pos_unpack(
    input logic [POS_W-1:0] v
  );
    return pos_t'(v);
  endfunction

endpackage

// File: rtl/sga_tick_timer.sv
// Step-period counter: counts run cycles and emits a
// one-cycle tick on the last one, then wraps to zero.
module sga_tick_timer #(
  parameter int STEP_CYCLES = 25000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW =
    (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = run && !clr && (cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sga_step_scheduler.sv
// Snake movement sequencer: per tick moves the head, checks
// the border, shifts the body RAM and pulses the result.
module sga_step_scheduler
  import sga_pkg::*;
#(
  parameter int GRID_W      = 6,
  parameter int GRID_H      = 6,
  parameter int MAX_SIZE    = 16,
  parameter int STEP_CYCLES = 25000000,
  parameter int PLAY_STEPS  = 255,
  parameter logic [5:0] INIT_HEAD = 6'o22
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       enable,
  input  logic       pause,
  input  logic [3:0] buttons,
  input  logic [3:0] size,
  input  logic [5:0] apple_pos,
  input  logic [5:0] mem_rdata,
  output logic [3:0] mem_addr,
  output logic       mem_we,
  output logic [5:0] mem_wdata,
  output logic [5:0] head_pos,
  output logic [1:0] direction,
  output logic       is_at_apple,
  output logic       is_at_border,
  output logic       is_at_body,
  output logic       end_play_time,
  output logic       step_done,
  output logic       busy
);

  localparam logic [2:0] X_MAX = 3'(GRID_W - 1);
  localparam logic [2:0] Y_MAX = 3'(GRID_H - 1);
  localparam logic [4:0] SZ_MAX = 5'(MAX_SIZE);
  localparam logic [7:0] STEPS_END = 8'(PLAY_STEPS);

  state_t     state, state_nx;
  dir_t       dir_q, pend_dir, btn_dir;
  pos_t       head_q, nh_q, nh_c;
  logic [3:0] idx, idx_c;
  logic [7:0] step_cnt;
  logic       btn_ok, border_c, grow_c;
  logic       border_f, body_f;
  logic       run, tick;

  assign head_pos  = head_q;
  assign direction = dir_q;
  assign run = (state == S_WAIT) && enable
            && !pause && !end_play_time;

  sga_tick_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (restart || !enable),
    .run    (run),
    .tick   (tick)
  );

  always_comb begin
    btn_ok  = 1'b1;
    btn_dir = DIR_RIGHT;
    case (buttons)
      4'b1000: btn_dir = DIR_UP;
      4'b0100: btn_dir = DIR_DOWN;
      4'b0010: btn_dir = DIR_LEFT;
      4'b0001: btn_dir = DIR_RIGHT;
      default: btn_ok  = 1'b0;
    endcase
    if (btn_dir == dir_opposite(dir_q)) begin
      btn_ok = 1'b0;
    end
  end

  always_comb begin
    nh_c     = head_q;
    border_c = 1'b0;
    unique case (pend_dir)
      DIR_UP: begin
        border_c = (head_q.y == 3'd0);
        nh_c.y   = head_q.y - 3'd1;
      end
      DIR_DOWN: begin
        border_c = (head_q.y == Y_MAX);
        nh_c.y   = head_q.y + 3'd1;
      end
      DIR_LEFT: begin
        border_c = (head_q.x == 3'd0);
        nh_c.x   = head_q.x - 3'd1;
      end
      DIR_RIGHT: begin
        border_c = (head_q.x == X_MAX);
        nh_c.x   = head_q.x + 3'd1;
      end
    endcase
    grow_c = (nh_c == pos_unpack(apple_pos))
          && ({1'b0, size} < SZ_MAX);
    idx_c  = grow_c ? size : size - 4'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:   state_nx = S_WAIT;
      S_WAIT:   if (tick) state_nx = S_CALC;
      S_CALC: begin
        if (border_c)         state_nx = S_REPORT;
        else if (idx_c == '0) state_nx = S_WHEAD;
        else                  state_nx = S_RD;
      end
      S_RD:     state_nx = S_SHIFT;
      S_SHIFT:  state_nx = (idx == 4'd1) ? S_WHEAD : S_RD;
      S_WHEAD:  state_nx = S_REPORT;
      S_REPORT: state_nx = S_WAIT;
      default:  state_nx = S_INIT;
    endcase
    if (restart) begin
      state_nx = S_INIT;
    end
  end

  // Nothing is written while reset is held; INIT writes after.
  always_comb begin
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    step_done    = 1'b0;
    is_at_apple  = 1'b0;
    is_at_border = 1'b0;
    is_at_body   = 1'b0;
    unique case (state)
      S_INIT: begin
        mem_we    = reset_n;
        mem_wdata = INIT_HEAD;
      end
      S_RD: mem_addr = idx - 4'd1;
      S_SHIFT: begin
        mem_addr  = idx;
        mem_we    = 1'b1;
        mem_wdata = mem_rdata;
      end
      S_WHEAD: begin
        mem_we    = 1'b1;
        mem_wdata = nh_q;
      end
      S_REPORT: begin
        step_done    = 1'b1;
        is_at_border = border_f;
        is_at_body   = body_f;
        is_at_apple  = !border_f
          && (nh_q == pos_unpack(apple_pos));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dir_q         <= DIR_RIGHT;
      pend_dir      <= DIR_RIGHT;
      head_q        <= pos_unpack(INIT_HEAD);
      nh_q          <= pos_unpack(INIT_HEAD);
      idx           <= '0;
      border_f      <= 1'b0;
      body_f        <= 1'b0;
      busy          <= 1'b0;
      step_cnt      <= '0;
      end_play_time <= 1'b0;
    end else if (restart) begin
      dir_q         <= DIR_RIGHT;
      pend_dir      <= DIR_RIGHT;
      head_q        <= pos_unpack(INIT_HEAD);
      nh_q          <= pos_unpack(INIT_HEAD);
      idx           <= '0;
      border_f      <= 1'b0;
      body_f        <= 1'b0;
      busy          <= 1'b0;
      step_cnt      <= '0;
      end_play_time <= 1'b0;
    end else begin
      if (btn_ok) begin
        pend_dir <= btn_dir;
      end
      unique case (state)
        S_WAIT: if (tick) busy <= 1'b1;
        S_CALC: begin
          dir_q    <= pend_dir;
          nh_q     <= nh_c;
          border_f <= border_c;
          idx      <= idx_c;
        end
        S_SHIFT: begin
          if (pos_unpack(mem_rdata) == nh_q) begin
            body_f <= 1'b1;
          end
          idx <= idx - 4'd1;
        end
        S_WHEAD: head_q <= nh_q;
        S_REPORT: begin
          border_f <= 1'b0;
          body_f   <= 1'b0;
          busy     <= 1'b0;
          step_cnt <= step_cnt + 8'd1;
          if (step_cnt + 8'd1 == STEPS_END) begin
            end_play_time <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sga_step_scheduler.sv
// Randomized scoreboard bench for sga_step_scheduler with a
// queue-based snake model and a behavioural body RAM.
module tb_sga_step_scheduler;

  localparam int STEP = 10;
  localparam int PLAY = 30;
  localparam int MAXS = 8;
  localparam int GW   = 6;
  localparam int GH   = 6;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       restart = 1'b0;
  logic       enable = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] buttons = 4'b0;
  logic [3:0] size = 4'd1;
  logic [5:0] apple_pos = 6'o55;
  logic [5:0] mem_rdata;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [5:0] mem_wdata;
  logic [5:0] head_pos;
  logic [1:0] direction;
  logic       is_at_apple, is_at_border, is_at_body;
  logic       end_play_time, step_done, busy;

  sga_step_scheduler #(
    .GRID_W(GW), .GRID_H(GH), .MAX_SIZE(MAXS),
    .STEP_CYCLES(STEP), .PLAY_STEPS(PLAY),
    .INIT_HEAD(6'o22)
  ) dut (
    .clock(clock), .reset_n(reset_n), .restart(restart),
    .enable(enable), .pause(pause), .buttons(buttons),
    .size(size), .apple_pos(apple_pos),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .head_pos(head_pos), .direction(direction),
    .is_at_apple(is_at_apple), .is_at_border(is_at_border),
    .is_at_body(is_at_body), .end_play_time(end_play_time),
    .step_done(step_done), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [5:0] ram [16];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic       ap, bd, by;
    int         lat, wr;
    logic [5:0] head;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, rise_cyc = 0, n_rise = 0, wr_cnt = 0;
  int entry_cyc = 0;

  logic [1:0] m_dir, m_pend;
  logic [5:0] body[$];
  int m_steps;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic void dir_delta(input logic [1:0] d,
                                    output int dx,
                                    output int dy);
    dx = 0;
    dy = 0;
    case (d)
      2'd0: dy = -1;
      2'd1: dy = 1;
      2'd2: dx = -1;
      default: dx = 1;
    endcase
  endfunction

  task automatic model_reset();
    body = {6'o22};
    m_dir = 2'd3;
    m_pend = 2'd3;
    m_steps = 0;
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    exp_t e;
    logic busy_q;
    busy_q = 1'b0;
    forever begin
      @(negedge clock);
      if (busy && !busy_q) begin
        rise_cyc = cyc;
        n_rise++;
        wr_cnt = 0;
      end
      busy_q = busy;
      if (busy && mem_we) wr_cnt++;
      if (step_done) begin
        if (sbq.size() == 0) begin
          fail_now("spurious_step_done");
        end else begin
          e = sbq.pop_front();
          check("apple", 32'(is_at_apple), 32'(e.ap));
          check("border", 32'(is_at_border), 32'(e.bd));
          check("body", 32'(is_at_body), 32'(e.by));
          check("latency", cyc - rise_cyc + 1, e.lat);
          check("ram_writes", wr_cnt, e.wr);
          check("head", 32'(head_pos), 32'(e.head));
        end
      end else if (is_at_apple || is_at_border || is_at_body) begin
        fail_now("stray_pulse");
      end
    end
  end

  task automatic press(input logic [3:0] b);
    int d;
    buttons = b;
    case (b)
      4'b1000: d = 0;
      4'b0100: d = 1;
      4'b0010: d = 2;
      4'b0001: d = 3;
      default: d = -1;
    endcase
    if (d >= 0 && d != opp(int'(m_dir))) m_pend = 2'(d);
    @(negedge clock);
    buttons = 4'b0;
  endtask

  // Called in the first WAIT cycle; returns the expected
  // number of cycles until the step's first busy cycle.
  task automatic setup_step(input bit fixed,
                            input bit no_extra,
                            output int period);
    int np, dx, dy, x, y, nx, ny, r, n, ncmp;
    logic [3:0] b;
    logic [5:0] nh;
    bit grow, hit;
    exp_t e;
    entry_cyc = cyc;
    np = fixed ? 0 : $urandom_range(0, 2);
    for (int i = 0; i < np; i++) begin
      case ($urandom_range(0, 4))
        0: b = 4'b0;
        1: b = 4'($urandom);
        default: b = 4'(4'b0001 << $urandom_range(0, 3));
      endcase
      press(b);
    end
    x = int'(body[0][5:3]);
    y = int'(body[0][2:0]);
    dir_delta(m_pend, dx, dy);
    nx = x + dx;
    ny = y + dy;
    if (fixed) begin
      apple_pos = 6'o55;
    end else if ($urandom_range(0, 1) == 1 && nx >= 0
                 && nx < GW && ny >= 0 && ny < GH) begin
      apple_pos = {3'(nx), 3'(ny)};
    end else begin
      apple_pos = {3'($urandom_range(0, GW - 1)),
                   3'($urandom_range(0, GH - 1))};
    end
    size = 4'(body.size());
    m_dir = m_pend;
    m_steps++;
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
      e = '{ap: 1'b0, bd: 1'b1, by: 1'b0, lat: 2, wr: 0,
            head: body[0]};
    end else begin
      nh = {3'(nx), 3'(ny)};
      grow = (nh == apple_pos) && (body.size() < MAXS);
      ncmp = grow ? body.size() : body.size() - 1;
      hit = 1'b0;
      for (int k = 0; k < ncmp; k++)
        if (body[k] == nh) hit = 1'b1;
      body.push_front(nh);
      if (!grow) void'(body.pop_back());
      e = '{ap: (nh == apple_pos), bd: 1'b0, by: hit,
            lat: 2 * ncmp + 3, wr: ncmp + 1, head: nh};
    end
    sbq.push_back(e);
    period = STEP;
    r = (fixed || no_extra) ? 0 : $urandom_range(0, 9);
    if (r >= 5 && r <= 7) begin
      n = $urandom_range(1, 6);
      pause = 1'b1;
      repeat (n) @(negedge clock);
      pause = 1'b0;
      period = STEP + n;
    end else if (r >= 8) begin
      n = $urandom_range(1, 4);
      enable = 1'b0;
      repeat (n) @(negedge clock);
      enable = 1'b1;
      period = np + n + STEP;
    end
  endtask

  task automatic finish_step(input int period);
    bit seen;
    int bad;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clock);
      seen = step_done;
    end
    if (!seen) begin
      fail_now("step_timeout");
    end else begin
      check("tick_period", rise_cyc - entry_cyc, period);
      @(negedge clock);
      check("end_play", 32'(end_play_time),
            32'(m_steps >= PLAY));
      check("direction", 32'(direction), 32'(m_dir));
      bad = 0;
      for (int k = 0; k < body.size(); k++)
        if (ram[k] !== body[k]) bad++;
      check("ram_image", bad, 0);
    end
  endtask

  task automatic wait_busy();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clock);
      seen = busy;
    end
    if (!seen) fail_now("busy_timeout");
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    sbq.delete();
    model_reset();
    check("rs_end", 32'(end_play_time), 32'd0);
    check("rs_head", 32'(head_pos), 32'o22);
    check("rs_dir", 32'(direction), 32'd3);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_init_we", 32'(mem_we), 32'd1);
    check("rs_init_data", 32'(mem_wdata), 32'o22);
    @(negedge clock);
    check("rs_ram0", 32'(ram[0]), 32'o22);
  endtask

  initial begin
    int p, n0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_dir", 32'(direction), 32'd3);
    check("rst_head", 32'(head_pos), 32'o22);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_end", 32'(end_play_time), 32'd0);
    check("rst_done", 32'(step_done), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    enable = 1'b1;
    #1;
    check("init_we", 32'(mem_we), 32'd1);
    check("init_data", 32'(mem_wdata), 32'o22);
    @(negedge clock);

    setup_step(1'b1, 1'b1, p);
    finish_step(p);
    for (int i = 1; i < PLAY; i++) begin
      setup_step(1'b0, 1'b0, p);
      finish_step(p);
    end

    n0 = n_rise;
    repeat (40) @(negedge clock);
    check("no_step_after_end", n_rise - n0, 0);
    check("end_held", 32'(end_play_time), 32'd1);
    do_restart();

    setup_step(1'b0, 1'b1, p);
    wait_busy();
    do_restart();

    for (int i = 0; i < 12; i++) begin
      setup_step(1'b0, 1'b0, p);
      finish_step(p);
    end

    setup_step(1'b0, 1'b1, p);
    wait_busy();
    pause = 1'b1;
    finish_step(p);
    n0 = n_rise;
    repeat (25) @(negedge clock);
    check("paused_no_step", n_rise - n0, 0);
    pause = 1'b0;

    check("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
